// File: rtl/sub_16_bit_seq.sv
// Sequential 16-bit subtractor: d = a - b - b_in computed as a + ~b + ~b_in,
// one 4-bit slice per clock, with start/busy/done handshake and result flags.
module sub_16_bit_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        b_in,
  output logic [15:0] d,
  output logic        b_out,
  output logic        ovf,
  output logic        zero,
  output logic        neg,
  output logic        busy,
  output logic        done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] d_r;
  logic [1:0]  k_r;
  logic        c_r;
  logic        load_s;
  logic        step_s;
  logic        finish_s;
  logic [3:0]  slice_a_s;
  logic [3:0]  slice_b_s;
  logic [4:0]  sum_s;
  logic [15:0] result_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: CALC lasts exactly four slice edges
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = CALC;
        else       next_state_s = IDLE;
      end
      CALC: begin
        if (k_r == 2'd3) next_state_s = IDLE;
        else             next_state_s = CALC;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Control decode; start is only looked at while idle
  always_comb begin
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = start;
      end
      CALC: begin
        step_s   = 1'b1;
        finish_s = (k_r == 2'd3);
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Current slice sum; the final slice is merged with the shadow for the full result
  always_comb begin
    slice_a_s = a_r[{k_r, 2'b00} +: 4];
    slice_b_s = ~b_r[{k_r, 2'b00} +: 4];
    sum_s     = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {4'b0000, c_r};
    result_s  = d_r;
    result_s[15:12] = sum_s[3:0];
  end

  // Operand capture, slice counter, carry chain and shadow difference
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= 16'h0000;
      b_r <= 16'h0000;
      d_r <= 16'h0000;
      k_r <= 2'd0;
      c_r <= 1'b0;
    end else if (load_s) begin
      a_r <= a;
      b_r <= b;
      d_r <= 16'h0000;
      k_r <= 2'd0;
      c_r <= ~b_in;
    end else if (step_s) begin
      d_r[{k_r, 2'b00} +: 4] <= sum_s[3:0];
      c_r <= sum_s[4];
      k_r <= k_r + 2'd1;
    end
  end

  // Visible results and handshake; results change only on the completion edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d     <= 16'h0000;
      b_out <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (next_state_s == CALC);
      done <= finish_s;
      if (finish_s) begin
        d     <= result_s;
        b_out <= ~sum_s[4];
        ovf   <= (a_r[15] ^ b_r[15]) & (result_s[15] ^ a_r[15]);
        zero  <= (result_s == 16'h0000);
        neg   <= result_s[15];
      end
    end
  end

endmodule

// File: tb/tb_sub_16_bit_seq.sv
// Self-checking bench for sub_16_bit_seq: directed plan cases plus randomized
// operations checked against an integer-arithmetic reference model.
module tb_sub_16_bit_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic [15:0] d;
  logic        b_out;
  logic        ovf;
  logic        zero;
  logic        neg;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  sub_16_bit_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (b_in),
    .d    (d),
    .b_out(b_out),
    .ovf  (ovf),
    .zero (zero),
    .neg  (neg),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {d, b_out, ovf, zero, neg, busy, done} at the completion cycle
  function automatic logic [21:0] model(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    int ud;
    int sd;
    logic [15:0] dd;
    ud = int'(av) - int'(bv) - int'(bi);
    sd = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    dd = ud[15:0];
    return {dd, (ud < 0), ((sd > 32767) || (sd < -32768)), (dd == 16'h0000), dd[15], 1'b0, 1'b1};
  endfunction

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                        output logic [21:0] obs, output int lat, output logic busy_ok);
    @(negedge clk);
    a = av; b = bv; b_in = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 12) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    obs = {d, b_out, ovf, zero, neg, busy, done};
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    logic [21:0] exp;
    int n;
    rst = 1'b1; start = 1'b1; a = 16'd500; b = 16'd200; b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({d, b_out, ovf, zero, neg, busy, done} !== 22'd0) begin
      errors++;
      $display("FAIL reset_state obs=%h exp=0", {d, b_out, ovf, zero, neg, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_accept busy=%b exp=1", busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    obs = {d, b_out, ovf, zero, neg, busy, done};
    exp = model(16'd500, 16'd200, 1'b0);
    checks++;
    if (obs !== exp || n != 4) begin
      errors++;
      $display("FAIL reset_release_op obs=%h lat=%0d exp=%h lat=4", obs, n, exp);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic        tbi[4];
    logic [15:0] td [4];
    logic [21:0] obs;
    logic [21:0] exp;
    logic [15:0] held;
    int lat;
    logic busy_ok;
    ta  = '{16'd32445, 16'd12500, 16'h8000, 16'h0000};
    tb  = '{16'd16785, 16'd40535, 16'h0001, 16'h0000};
    tbi = '{1'b0, 1'b1, 1'b0, 1'b1};
    td  = '{16'd15660, 16'd37500, 16'h7FFF, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tbi[i], obs, lat, busy_ok);
      exp = model(ta[i], tb[i], tbi[i]);
      checks++;
      if (obs !== exp || obs[21:6] !== td[i]) begin
        errors++;
        $display("FAIL directed[%0d] obs=%h exp=%h d_exp=%h", i, obs, exp, td[i]);
      end
      checks++;
      if (lat != 4 || busy_ok !== 1'b1) begin
        errors++;
        $display("FAIL directed_timing[%0d] lat=%0d busy_ok=%b exp lat=4 busy_ok=1", i, lat, busy_ok);
      end
      held = d;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || d !== held) begin
        errors++;
        $display("FAIL done_pulse[%0d] done=%b d=%h exp done=0 d=%h", i, done, d, held);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] obs;
    int n1;
    int n2;
    @(negedge clk);
    a = 16'd16785; b = 16'd32445; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'd25020; b = 16'd25020;
    n1 = 0;
    while (done !== 1'b1 && n1 < 12) begin
      @(posedge clk); #1;
      n1++;
    end
    obs = {d, b_out, ovf, zero, neg, busy, done};
    checks++;
    if (obs !== model(16'd16785, 16'd32445, 1'b0) || n1 != 4) begin
      errors++;
      $display("FAIL b2b_first obs=%h lat=%0d exp=%h lat=4", obs, n1, model(16'd16785, 16'd32445, 1'b0));
    end
    n2 = 0;
    do begin
      @(posedge clk); #1;
      n2++;
    end while (done !== 1'b1 && n2 < 12);
    obs = {d, b_out, ovf, zero, neg, busy, done};
    start = 1'b0;
    checks++;
    if (obs !== model(16'd25020, 16'd25020, 1'b0) || n2 != 5) begin
      errors++;
      $display("FAIL b2b_second obs=%h gap=%0d exp=%h gap=5", obs, n2, model(16'd25020, 16'd25020, 1'b0));
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_release busy=%b exp=0", busy);
    end
  endtask

  task automatic test_start_busy();
    int dones;
    logic [15:0] dseen;
    @(negedge clk);
    a = 16'd100; b = 16'd1; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'd5; b = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    dseen = 16'hDEAD;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        dones++;
        dseen = d;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 1 || dseen !== 16'd99) begin
      errors++;
      $display("FAIL start_while_busy dones=%0d d=%0d exp dones=1 d=99", dones, dseen);
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] obs;
    int lat;
    logic busy_ok;
    int dones;
    @(negedge clk);
    a = 16'd1234; b = 16'd77; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({d, b_out, ovf, zero, neg, busy, done} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid_clear obs=%h exp=0", {d, b_out, ovf, zero, neg, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done dones=%0d exp=0", dones);
    end
    run_op(16'd7, 16'd3, 1'b0, obs, lat, busy_ok);
    checks++;
    if (obs !== model(16'd7, 16'd3, 1'b0) || obs[21:6] !== 16'd4 || lat != 4) begin
      errors++;
      $display("FAIL reset_mid_recover obs=%h lat=%0d exp=%h lat=4", obs, lat, model(16'd7, 16'd3, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [15:0] corners [6];
    logic [15:0] av;
    logic [15:0] bv;
    logic        bi;
    logic [21:0] obs;
    logic [21:0] exp;
    int lat;
    logic busy_ok;
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    for (int i = 0; i < 40; i++) begin
      av = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      bi = 1'($urandom);
      run_op(av, bv, bi, obs, lat, busy_ok);
      exp = model(av, bv, bi);
      checks++;
      if (obs !== exp || lat != 4 || busy_ok !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h bin=%b obs=%h lat=%0d busy_ok=%b exp=%h lat=4",
                 i, av, bv, bi, obs, lat, busy_ok, exp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
